// File: rtl/pix_mem_arbiter.sv
// Pixel memory arbiter: CPU-priority access to the single-port pixel RAM
// with a bounded-wait counter that guarantees the display a periodic slot.
module pix_mem_arbiter #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stall,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_gnt,
    output logic              disp_rvalid,
    output logic [DATA_W-1:0] disp_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_DISP
    } owner_e;

    localparam logic [3:0] WAIT_MAX = 4'(MAX_WAIT);

    owner_e            rd_owner;
    owner_e            rd_owner_nxt;
    logic [3:0]        wait_cnt;
    logic [3:0]        wait_cnt_nxt;
    logic              force_disp;
    logic              cpu_grant;
    logic              disp_grant;
    logic [DATA_W-1:0] cpu_rdata_q;
    logic [DATA_W-1:0] disp_rdata_q;

    assign force_disp = disp_req & (wait_cnt == WAIT_MAX);

    // Select terms are made mutually exclusive so the decode is one-hot.
    always_comb begin
        cpu_grant  = 1'b0;
        disp_grant = 1'b0;
        unique case (1'b1)
            force_disp:                           disp_grant = 1'b1;
            (cpu_req & ~force_disp):              cpu_grant  = 1'b1;
            (disp_req & ~cpu_req & ~force_disp):  disp_grant = 1'b1;
            default: ;
        endcase
    end

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_grant) begin
            mem_en    = 1'b1;
            mem_we    = cpu_we;
            mem_addr  = cpu_addr;
            mem_wdata = cpu_we ? cpu_wdata : '0;
        end else if (disp_grant) begin
            mem_en   = 1'b1;
            mem_addr = disp_addr;
        end
    end

    assign cpu_stall = cpu_req & ~cpu_grant;
    assign disp_gnt  = disp_grant;

    always_comb begin
        wait_cnt_nxt = wait_cnt;
        if (disp_grant) begin
            wait_cnt_nxt = 4'd0;
        end else if (disp_req && (wait_cnt != WAIT_MAX)) begin
            wait_cnt_nxt = wait_cnt + 4'd1;
        end
    end

    always_comb begin
        rd_owner_nxt = OWN_NONE;
        if (cpu_grant && !cpu_we) begin
            rd_owner_nxt = OWN_CPU;
        end else if (disp_grant) begin
            rd_owner_nxt = OWN_DISP;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_owner <= OWN_NONE;
            wait_cnt <= 4'd0;
        end else begin
            rd_owner <= rd_owner_nxt;
            wait_cnt <= wait_cnt_nxt;
        end
    end

    // Hold registers keep the last delivered word for the idle side.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cpu_rdata_q  <= '0;
            disp_rdata_q <= '0;
        end else begin
            if (rd_owner == OWN_CPU) begin
                cpu_rdata_q <= mem_rdata;
            end
            if (rd_owner == OWN_DISP) begin
                disp_rdata_q <= mem_rdata;
            end
        end
    end

    assign cpu_rvalid  = (rd_owner == OWN_CPU);
    assign disp_rvalid = (rd_owner == OWN_DISP);
    assign cpu_rdata   = cpu_rvalid ? mem_rdata : cpu_rdata_q;
    assign disp_rdata  = disp_rvalid ? mem_rdata : disp_rdata_q;

endmodule

// File: tb/tb_pix_mem_arbiter.sv
// Bench for pix_mem_arbiter: vector table with expected grant/stall,
// RAM model, and read-data scoreboard queues.
module tb_pix_mem_arbiter;

    logic        clk;
    logic        rst;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_stall;
    logic        cpu_rvalid;
    logic [31:0] cpu_rdata;
    logic        disp_req;
    logic [15:0] disp_addr;
    logic        disp_gnt;
    logic        disp_rvalid;
    logic [31:0] disp_rdata;
    logic        mem_en;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    pix_mem_arbiter #(
        .ADDR_W(16),
        .DATA_W(32),
        .MAX_WAIT(4)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cpu_req(cpu_req),
        .cpu_we(cpu_we),
        .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata),
        .cpu_stall(cpu_stall),
        .cpu_rvalid(cpu_rvalid),
        .cpu_rdata(cpu_rdata),
        .disp_req(disp_req),
        .disp_addr(disp_addr),
        .disp_gnt(disp_gnt),
        .disp_rvalid(disp_rvalid),
        .disp_rdata(disp_rdata),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] ram [65536];

    function automatic logic [31:0] pat(input logic [15:0] a);
        return {a ^ 16'hC3C3, a};
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) begin
            ram[i] = pat(16'(i));
        end
        mem_rdata = 32'h0;
    end

    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) ram[mem_addr] <= mem_wdata;
            else        mem_rdata     <= ram[mem_addr];
        end
    end

    typedef struct {
        bit          rst_before;
        bit          cr;
        bit          cw;
        logic [15:0] ca;
        logic [31:0] cd;
        bit          dr;
        logic [15:0] da;
        bit          e_stall;
        bit          e_gnt;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] shadow [logic [15:0]];
    logic [31:0] cpu_q[$];
    logic [31:0] disp_q[$];
    int          own;
    logic [31:0] last_cpu;
    logic [31:0] last_disp;
    int          n_checks;
    int          n_fail;

    function automatic logic [31:0] exp_data(input logic [15:0] a);
        if (shadow.exists(a)) return shadow[a];
        return pat(a);
    endfunction

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endtask

    task automatic add(input bit rb, input bit cr, input bit cw,
                       input logic [15:0] ca, input logic [31:0] cd,
                       input bit dr, input logic [15:0] da,
                       input bit es, input bit eg);
        vec_t v;
        v.rst_before = rb;
        v.cr = cr;
        v.cw = cw;
        v.ca = ca;
        v.cd = cd;
        v.dr = dr;
        v.da = da;
        v.e_stall = es;
        v.e_gnt = eg;
        vecs.push_back(v);
    endtask

    task automatic clear_model();
        cpu_q.delete();
        disp_q.delete();
        own = 0;
        last_cpu = 32'h0;
        last_disp = 32'h0;
    endtask

    task automatic drive_idle();
        cpu_req = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = 16'h0;
        cpu_wdata = 32'h0;
        disp_req = 1'b0;
        disp_addr = 16'h0;
    endtask

    // Called at a falling edge; returns at the next falling edge.
    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        #1;
        chk("rst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("rst_disp_rvalid", 32'(disp_rvalid), 32'h0);
        chk("rst_cpu_rdata", cpu_rdata, 32'h0);
        chk("rst_disp_rdata", disp_rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
    endtask

    task automatic step(input vec_t v);
        logic        cg;
        logic [15:0] ea;
        logic [31:0] e;
        cpu_req = v.cr;
        cpu_we = v.cw;
        cpu_addr = v.ca;
        cpu_wdata = v.cd;
        disp_req = v.dr;
        disp_addr = v.da;
        #4;
        cg = v.cr & ~v.e_stall;
        ea = cg ? v.ca : (v.e_gnt ? v.da : 16'h0);
        chk("cpu_stall", 32'(cpu_stall), 32'(v.e_stall));
        chk("disp_gnt", 32'(disp_gnt), 32'(v.e_gnt));
        chk("mem_en", 32'(mem_en), 32'(cg | v.e_gnt));
        chk("mem_we", 32'(mem_we), 32'(cg & v.cw));
        chk("mem_addr", 32'(mem_addr), 32'(ea));
        if (cg && v.cw) chk("mem_wdata", mem_wdata, v.cd);
        if (!cg && !v.e_gnt) chk("mem_wdata_idle", mem_wdata, 32'h0);
        chk("cpu_rvalid", 32'(cpu_rvalid), 32'(own == 1));
        chk("disp_rvalid", 32'(disp_rvalid), 32'(own == 2));
        if (own == 1 && cpu_q.size() > 0) begin
            e = cpu_q.pop_front();
            chk("cpu_rdata", cpu_rdata, e);
            last_cpu = e;
        end else begin
            chk("cpu_rdata_hold", cpu_rdata, last_cpu);
        end
        if (own == 2 && disp_q.size() > 0) begin
            e = disp_q.pop_front();
            chk("disp_rdata", disp_rdata, e);
            last_disp = e;
        end else begin
            chk("disp_rdata_hold", disp_rdata, last_disp);
        end
        @(posedge clk);
        own = 0;
        if (cg && !v.cw) begin
            cpu_q.push_back(exp_data(v.ca));
            own = 1;
        end else if (v.e_gnt) begin
            disp_q.push_back(exp_data(v.da));
            own = 2;
        end
        if (cg && v.cw) shadow[v.ca] = v.cd;
        @(negedge clk);
    endtask

    initial begin
        vec_t v;
        n_checks = 0;
        n_fail = 0;
        rst = 1'b1;
        drive_idle();
        clear_model();

        // reset state, then CPU write/read with no display traffic
        add(1, 0, 0, 16'h0000, 32'h0, 0, 16'h0000, 0, 0);
        add(0, 1, 1, 16'h0010, 32'hDEADBEEF, 0, 16'h0000, 0, 0);
        add(0, 1, 0, 16'h0010, 32'h0, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 16'h0000, 32'h0, 0, 16'h0000, 0, 0);
        // display alone
        add(1, 0, 0, 16'h0000, 32'h0, 1, 16'h0123, 0, 1);
        add(0, 0, 0, 16'h0000, 32'h0, 0, 16'h0000, 0, 0);
        // continuous contention, period 5
        for (int i = 0; i < 10; i++) begin
            add(0, 1, 0, 16'h0300 + 16'(i), 32'h0,
                1, 16'h0200 + 16'(i / 5),
                (i % 5) == 4, (i % 5) == 4);
        end
        add(0, 0, 0, 16'h0000, 32'h0, 0, 16'h0000, 0, 0);
        // display drops request before grant: counter holds
        for (int i = 0; i < 3; i++) begin
            add(i == 0, 1, 0, 16'h0A00 + 16'(i), 32'h0,
                1, 16'h0B00, 0, 0);
        end
        add(0, 1, 0, 16'h0A03, 32'h0, 0, 16'h0000, 0, 0);
        add(0, 1, 0, 16'h0A04, 32'h0, 1, 16'h0B00, 0, 0);
        add(0, 1, 0, 16'h0A05, 32'h0, 1, 16'h0B00, 1, 1);
        add(0, 0, 0, 16'h0000, 32'h0, 0, 16'h0000, 0, 0);
        // interleaved reads
        add(1, 1, 0, 16'h0400, 32'h0, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 16'h0000, 32'h0, 1, 16'h0500, 0, 1);
        add(0, 1, 0, 16'h0600, 32'h0, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 16'h0000, 32'h0, 0, 16'h0000, 0, 0);
        // forced slot against a pending CPU write
        for (int i = 0; i < 4; i++) begin
            add(i == 0, 1, 0, 16'h0700 + 16'(i), 32'h0,
                1, 16'h0C00, 0, 0);
        end
        add(0, 1, 1, 16'h0800, 32'h12345678, 1, 16'h0C00, 1, 1);
        add(0, 1, 1, 16'h0800, 32'h12345678, 0, 16'h0000, 0, 0);
        add(0, 1, 0, 16'h0800, 32'h0, 0, 16'h0000, 0, 0);
        add(0, 0, 0, 16'h0000, 32'h0, 0, 16'h0000, 0, 0);

        @(negedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            if (v.rst_before) do_reset();
            step(v);
        end

        // reset while a CPU read is in flight
        do_reset();
        add(0, 1, 0, 16'h0900, 32'h0, 0, 16'h0000, 0, 0);
        step(vecs[vecs.size() - 1]);
        rst = 1'b1;
        drive_idle();
        #1;
        chk("midrst_cpu_rvalid", 32'(cpu_rvalid), 32'h0);
        chk("midrst_cpu_rdata", cpu_rdata, 32'h0);
        chk("midrst_disp_rvalid", 32'(disp_rvalid), 32'h0);
        @(negedge clk);
        rst = 1'b0;
        clear_model();
        add(0, 0, 0, 16'h0000, 32'h0, 0, 16'h0000, 0, 0);
        step(vecs[vecs.size() - 1]);
        step(vecs[vecs.size() - 1]);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
